// File: rtl/wb_mon_pkg.sv
// Shared types for the writeback trace monitor: FSM state encoding and verdict codes.
package wb_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_CHECK,
    ST_PASS,
    ST_FAIL
  } mon_state_t;

  localparam logic [1:0] FAIL_NONE    = 2'b00;
  localparam logic [1:0] FAIL_SIG     = 2'b01;
  localparam logic [1:0] FAIL_TIMEOUT = 2'b10;

endpackage

// File: rtl/wb_misr.sv
// Multiple-input signature register: shifts with polynomial feedback and folds in one data word per enable.
module wb_misr #(
  parameter int unsigned       DATA_W = 32,
  parameter logic [DATA_W-1:0] POLY   = DATA_W'(32'h04C11DB7),
  parameter logic [DATA_W-1:0] SEED   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] signature
);

  logic [DATA_W-1:0] sig_next;

  // Clear takes priority so a new run always starts from SEED.
  always_comb begin
    sig_next = signature;
    if (clear) begin
      sig_next = SEED;
    end else if (enable) begin
      sig_next = {signature[DATA_W-2:0], 1'b0}
               ^ (signature[DATA_W-1] ? POLY : '0)
               ^ data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      signature <= SEED;
    end else begin
      signature <= sig_next;
    end
  end

endmodule

// File: rtl/wb_trace_monitor.sv
// Writeback trace monitor: MISR signature, retire/cycle counters and a pass/fail verdict per run.
// Define WB_HIST_EN to add a readable history buffer of the most recent accepted writes.
module wb_trace_monitor
  import wb_mon_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       CNT_W      = 16,
  parameter int unsigned       CYC_W      = 20,
  parameter int unsigned       MAX_CYCLES = 60,
  parameter logic [31:0]       POLY       = 32'h04C11DB7,
  parameter logic [DATA_W-1:0] SEED       = '0
`ifdef WB_HIST_EN
  , parameter int unsigned     HIST_DEPTH = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] exp_sig,
  input  logic [CNT_W-1:0]  exp_count,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [DATA_W-1:0] signature,
  output logic [CNT_W-1:0]  retire_count,
  output logic [CYC_W-1:0]  cycle_count
`ifdef WB_HIST_EN
  , input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [DATA_W-1:0]               hist_data
`endif
);

  localparam logic [CYC_W-1:0] TIMEOUT_AT = CYC_W'(MAX_CYCLES - 1);

  mon_state_t       state_q, state_d;
  logic [CNT_W-1:0] exp_count_q;
  logic [1:0]       fail_d;
  logic             run_start;
  logic             misr_clear;
  logic             misr_en;
  logic             accept;
  logic             last_write;
  logic             timeout;
  logic             busy_d, done_d, pass_d;

  assign accept     = wb_valid && (state_q == ST_RUN);
  assign last_write = accept && ((retire_count + CNT_W'(1)) == exp_count_q);
  assign timeout    = (cycle_count >= TIMEOUT_AT);

  wb_misr #(
    .DATA_W (DATA_W),
    .POLY   (DATA_W'(POLY)),
    .SEED   (SEED)
  ) u_misr (
    .clk       (clk),
    .reset     (reset),
    .clear     (misr_clear),
    .enable    (misr_en),
    .data      (wb_data),
    .signature (signature)
  );

  // Next-state and control decode; completion is tested before timeout so it wins a tie.
  always_comb begin
    state_d    = state_q;
    fail_d     = fail_code;
    run_start  = 1'b0;
    misr_clear = 1'b0;
    misr_en    = 1'b0;
    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) begin
          run_start  = 1'b1;
          misr_clear = 1'b1;
          fail_d     = FAIL_NONE;
          state_d    = (exp_count == '0) ? ST_CHECK : ST_RUN;
        end
      end
      ST_RUN: begin
        misr_en = wb_valid;
        if (last_write) begin
          state_d = ST_CHECK;
        end else if (timeout) begin
          state_d = ST_FAIL;
          fail_d  = FAIL_TIMEOUT;
        end
      end
      ST_CHECK: begin
        if (signature == exp_sig) begin
          state_d = ST_PASS;
        end else begin
          state_d = ST_FAIL;
          fail_d  = FAIL_SIG;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_CHECK);
    done_d = (state_d == ST_PASS) || (state_d == ST_FAIL);
    pass_d = (state_d == ST_PASS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      fail_code <= FAIL_NONE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state_q   <= state_d;
      fail_code <= fail_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
    end
  end

  // Run counters; cycle_count saturates, retire_count is bounded by the latched target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count  <= '0;
      retire_count <= '0;
      exp_count_q  <= '0;
    end else if (run_start) begin
      cycle_count  <= '0;
      retire_count <= '0;
      exp_count_q  <= exp_count;
    end else if (state_q == ST_RUN) begin
      if (cycle_count != '1) begin
        cycle_count <= cycle_count + CYC_W'(1);
      end
      if (accept) begin
        retire_count <= retire_count + CNT_W'(1);
      end
    end
  end

`ifdef WB_HIST_EN
  localparam int unsigned HIST_AW = $clog2(HIST_DEPTH);
  localparam logic [HIST_AW:0] HIST_FULL = (HIST_AW + 1)'(HIST_DEPTH);

  logic [DATA_W-1:0]  hist_mem [HIST_DEPTH];
  logic [HIST_AW-1:0] hist_wr_ptr;
  logic [HIST_AW:0]   hist_fill;
  logic [HIST_AW-1:0] hist_rd_slot;

  // Fill level masks slots left over from an earlier run so they read as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_wr_ptr <= '0;
      hist_fill   <= '0;
    end else if (run_start) begin
      hist_wr_ptr <= '0;
      hist_fill   <= '0;
    end else if (accept) begin
      hist_wr_ptr <= hist_wr_ptr + HIST_AW'(1);
      if (hist_fill != HIST_FULL) begin
        hist_fill <= hist_fill + (HIST_AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hist_mem[hist_wr_ptr] <= wb_data;
    end
  end

  assign hist_rd_slot = hist_wr_ptr - hist_idx - HIST_AW'(1);
  assign hist_data    = ({1'b0, hist_idx} < hist_fill) ? hist_mem[hist_rd_slot] : '0;
`endif

endmodule
